mmio_uart_tx: RTL

Memory-mapped serial transmitter on the CPU data bus: the responder for CPU stores and loads at two fixed byte addresses. Bytes stored to the data address go into a small FIFO. A transmit FSM sends them out as 8N1 frames on `txd`. The status address lets software poll FIFO state before storing. The block sits beside `memory` on the `mem_addr`/`mem_wr_en`/`mem_wr_data` bus. The top-level read mux selects `rd_data` when `sel` is high.

---
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter.
// Stores to DATA_ADDR feed a FIFO. Loads from STAT_ADDR report its state.
module mmio_uart_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DATA_ADDR  = 8'hFF,
  parameter logic [7:0]  STAT_ADDR  = 8'hFE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_addr,
  input  logic       mem_wr_en,
  input  logic [7:0] mem_wr_data,
  output logic [7:0] rd_data,
  output logic       sel,
  output logic       txd,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_txd;
  logic [7:0]    r_shift;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_timer;

  logic w_hit_data;
  logic w_hit_stat;
  logic w_full;
  logic w_empty;
  logic w_active;
  logic w_push;
  logic w_pop;
  logic w_ovf_set;
  logic w_ovf_clr;
  logic w_tick;
  logic [7:0] w_status;

  assign w_hit_data = (mem_addr == DATA_ADDR);
  assign w_hit_stat = (mem_addr == STAT_ADDR);
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_active   = (r_state != S_IDLE);
  assign w_tick     = (r_timer == T_LAST);

  // full is taken before any pop, so a store while full is always dropped
  assign w_push    = mem_wr_en && w_hit_data && !w_full;
  assign w_ovf_set = mem_wr_en && w_hit_data && w_full;
  assign w_ovf_clr = mem_wr_en && w_hit_stat && mem_wr_data[3];
  assign w_pop     = (r_state == S_IDLE) && !w_empty;

  assign w_status = {4'b0, r_ovf, w_active, w_full, w_empty};

  assign txd  = r_txd;
  assign busy = w_active || !w_empty;

  // zero-latency read mux for the single-cycle CPU
  always_comb begin
    rd_data = '0;
    sel     = 1'b0;
    if (w_hit_stat) begin
      sel     = 1'b1;
      rd_data = w_status;
    end else if (w_hit_data) begin
      sel     = 1'b1;
      rd_data = 8'(r_count);
    end
  end

  // FIFO storage; contents need no reset since pointers do
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wptr] <= mem_wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // sticky overflow flag; a same-cycle overflow beats the clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // frame FSM: start, 8 data bits LSB first, stop; txd registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_txd   <= 1'b1;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (!w_empty) begin
            r_shift <= r_mem[r_rptr];
            r_timer <= '0;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_timer <= '0;
            if (r_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + 3'd1;
              r_txd   <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_timer <= '0;
            r_txd   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
